// File: rtl/mpu_det_seq.sv
// mpu_det_seq: sequential signed determinant via the Leibniz sum, walking permutations with Heap's algorithm.
// One shared multiplier folds one element per cycle into prod; the accumulator adds or subtracts it by permutation parity.
module mpu_det_seq #(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 5,
    parameter int ACC_W  = 48
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [7:0]                       size,
    input  logic [DATA_W*MAX_N*MAX_N-1:0]    matrix,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic signed [ACC_W-1:0]          result
);
    localparam int IW = $clog2(MAX_N + 1);

    typedef enum logic [2:0] {IDLE, MUL, ACC, NEXT, DONE} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0]       m [MAX_N][MAX_N];
    logic [IW-1:0]           perm [MAX_N];
    logic [IW-1:0]           c [MAX_N];
    logic [IW-1:0]           n, i, j, a;
    logic                    sign, bad;
    logic [DATA_W-1:0]       e;
    logic signed [ACC_W-1:0] acc, prod, elem;

    assign bad  = size == 8'd0 || size > 8'(MAX_N);
    assign e    = m[j][perm[j]];
    assign elem = {{(ACC_W-DATA_W){e[DATA_W-1]}}, e};
    // Heap's rule: even i swaps with slot 0, odd i with slot c[i]
    assign a    = i[0] ? c[i] : '0;
    assign busy = state == MUL || state == ACC || state == NEXT;
    assign done = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = bad ? DONE : MUL;
            MUL:     if (j == n - IW'(1)) state_nx = ACC;
            ACC:     state_nx = NEXT;
            NEXT:    state_nx = (i == n) ? DONE : (c[i] < i) ? MUL : NEXT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < MAX_N; r++) begin
                perm[r] <= '0;
                c[r]    <= '0;
                for (int q = 0; q < MAX_N; q++) m[r][q] <= '0;
            end
            n      <= '0;
            i      <= '0;
            j      <= '0;
            sign   <= 1'b0;
            acc    <= '0;
            prod   <= '0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    for (int r = 0; r < MAX_N; r++) begin
                        perm[r] <= IW'(r);
                        c[r]    <= '0;
                        for (int q = 0; q < MAX_N; q++)
                            m[r][q] <= matrix[DATA_W*(r+MAX_N*q) +: DATA_W];
                    end
                    n    <= size[IW-1:0];
                    j    <= '0;
                    sign <= 1'b0;
                    acc  <= '0;
                    prod <= ACC_W'(1);
                    err  <= bad;
                    if (bad) result <= '0;
                end
                MUL: begin
                    prod <= prod * elem;
                    j    <= j + IW'(1);
                end
                ACC: begin
                    acc <= sign ? acc - prod : acc + prod;
                    i   <= IW'(1);
                end
                NEXT: begin
                    if (i == n) result <= acc;
                    else if (c[i] < i) begin
                        perm[a] <= perm[i];
                        perm[i] <= perm[a];
                        c[i]    <= c[i] + IW'(1);
                        sign    <= ~sign;
                        prod    <= ACC_W'(1);
                        j       <= '0;
                    end else begin
                        c[i] <= '0;
                        i    <= i + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
